// File: rtl/vpm_pkg.sv
// Shared types and constants for the variable-precision multiplier scheduler.
package vpm_pkg;

  localparam int OPW   = 32;
  localparam int PRODW = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } vpm_state_e;

  localparam logic [1:0] PREC_32  = 2'b00;
  localparam logic [1:0] PREC_16  = 2'b01;
  localparam logic [1:0] PREC_8   = 2'b10;
  localparam logic [1:0] PREC_MIX = 2'b11;

endpackage

// File: rtl/VariablePrecisionMultiplier.sv
// Combinational multiplier with lane splitting selected by the precision code.
// PREC_32: one 32x32 lane; PREC_16: two 16x16 lanes; PREC_8: four 8x8 lanes;
// PREC_MIX: 16x16 lane in the upper half, two 8x8 lanes in the lower half.
// SA/SB mark every A/B lane as two's complement.
module VariablePrecisionMultiplier
  import vpm_pkg::*;
(
  input  logic [OPW-1:0]   A,
  input  logic [OPW-1:0]   B,
  input  logic             SA,
  input  logic             SB,
  input  logic [1:0]       PREC,
  output logic [PRODW-1:0] OUT
);

  function automatic logic [63:0] mul32(input logic [31:0] a, input logic [31:0] b,
                                        input logic sa, input logic sb);
    logic signed [63:0] ea, eb;
    ea = {{32{sa & a[31]}}, a};
    eb = {{32{sb & b[31]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b,
                                        input logic sa, input logic sb);
    logic signed [31:0] ea, eb;
    ea = {{16{sa & a[15]}}, a};
    eb = {{16{sb & b[15]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b,
                                       input logic sa, input logic sb);
    logic signed [15:0] ea, eb;
    ea = {{8{sa & a[7]}}, a};
    eb = {{8{sb & b[7]}}, b};
    return ea * eb;
  endfunction

  // Lane products packed according to the precision code
  always_comb begin
    OUT = '0;
    case (PREC)
      PREC_32:  OUT = mul32(A, B, SA, SB);
      PREC_16:  OUT = {mul16(A[31:16], B[31:16], SA, SB), mul16(A[15:0], B[15:0], SA, SB)};
      PREC_8:   OUT = {mul8(A[31:24], B[31:24], SA, SB), mul8(A[23:16], B[23:16], SA, SB),
                       mul8(A[15:8], B[15:8], SA, SB),   mul8(A[7:0], B[7:0], SA, SB)};
      default:  OUT = {mul16(A[31:16], B[31:16], SA, SB),
                       mul8(A[15:8], B[15:8], SA, SB), mul8(A[7:0], B[7:0], SA, SB)};
    endcase
  end

endmodule

// File: rtl/vpm_rr_arbiter.sv
// Round-robin grant: first valid requester after last_grant, wrapping to 0.
module vpm_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [1:0]         last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         grant_idx,
  output logic               grant_any
);

  // Scan priority positions last_grant+1 .. last_grant+NUM_REQ; first hit wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req_valid[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
          grant_any = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = 2'(i);
        end
      end
    end
  end

endmodule

// File: rtl/vpm_scheduler.sv
// Shares one VariablePrecisionMultiplier among NUM_REQ requesters.
//   state     | meaning
//   ST_IDLE   | arbitrating; req_ready offered to the round-robin winner
//   ST_SETTLE | captured operands held on the multiplier, counter running
//   ST_RESP   | registered product presented until rsp_ready
module vpm_scheduler
  import vpm_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [OPW*NUM_REQ-1:0]   req_a,
  input  logic [OPW*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]       req_sa,
  input  logic [NUM_REQ-1:0]       req_sb,
  input  logic [2*NUM_REQ-1:0]     req_prec,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [PRODW-1:0]         rsp_data,
  output logic [1:0]               rsp_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  vpm_state_e         state, state_nx;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_idx;
  logic               grant_any;
  logic [1:0]         last_grant;
  logic [SCW-1:0]     settle_cnt;
  logic               take, sample, done;

  logic [OPW-1:0]     sel_a, sel_b, op_a, op_b;
  logic               sel_sa, sel_sb, op_sa, op_sb;
  logic [1:0]         sel_prec, op_prec;
  logic [PRODW-1:0]   mul_out;

  vpm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  // Multiplier sees only the captured operands, so bus changes after the handshake are ignored
  VariablePrecisionMultiplier u_mul (
    .A    (op_a),
    .B    (op_b),
    .SA   (op_sa),
    .SB   (op_sb),
    .PREC (op_prec),
    .OUT  (mul_out)
  );

  // Operand mux for the granted requester
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_sa   = 1'b0;
    sel_sb   = 1'b0;
    sel_prec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a    = req_a[OPW*i +: OPW];
        sel_b    = req_b[OPW*i +: OPW];
        sel_sa   = req_sa[i];
        sel_sb   = req_sb[i];
        sel_prec = req_prec[2*i +: 2];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state and handshake strobes
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    take      = 1'b0;
    sample    = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = grant;
        if (grant_any) begin
          take     = 1'b1;
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          sample   = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand capture, settle timer, response and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_sa      <= 1'b0;
      op_sb      <= 1'b0;
      op_prec    <= '0;
      last_grant <= 2'(NUM_REQ - 1);
      settle_cnt <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      op_count   <= '0;
    end else begin
      if (take) begin
        op_a       <= sel_a;
        op_b       <= sel_b;
        op_sa      <= sel_sa;
        op_sb      <= sel_sb;
        op_prec    <= sel_prec;
        rsp_id     <= grant_idx;
        last_grant <= grant_idx;
        settle_cnt <= SCW'(SETTLE_CYC - 1);
      end else if (state == ST_SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (sample) begin
        rsp_data  <= mul_out;
        rsp_valid <= 1'b1;
      end
      if (done) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 1'b1;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_vpm_scheduler.sv
// Bench for vpm_scheduler: directed scenarios plus randomized traffic against a
// cycle-count reference model and a lane-arithmetic golden multiplier.
module tb_vpm_scheduler;

  localparam int NR     = 2;
  localparam int SETTLE = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic [1:0]  prec;
  } op_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [32*NR-1:0] req_a, req_b;
  logic [NR-1:0]   req_sa, req_sb;
  logic [2*NR-1:0] req_prec;
  logic            rsp_valid, rsp_ready;
  logic [63:0]     rsp_data;
  logic [1:0]      rsp_id;
  logic            busy;
  logic [15:0]     op_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  op_t         pend[NR][$];
  int          m_phase;   // 0 idle, 1 settling, 2 responding
  int          m_rem;
  int          m_last;
  int          m_id;
  logic [63:0] m_data;
  logic [15:0] m_count;
  int          acc_id[$];
  logic [63:0] acc_data[$];

  vpm_scheduler #(.NUM_REQ(NR), .SETTLE_CYC(SETTLE), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sa    (req_sa),
    .req_sb    (req_sb),
    .req_prec  (req_prec),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic op_t mk_op(input logic [31:0] a, input logic [31:0] b,
                                input logic sa, input logic sb, input logic [1:0] prec);
    op_t o;
    o.a = a; o.b = b; o.sa = sa; o.sb = sb; o.prec = prec;
    return o;
  endfunction

  function automatic op_t rand_op();
    return mk_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)));
  endfunction

  // Lane-by-lane product computed with plain integer arithmetic
  function automatic logic [63:0] golden(input op_t o);
    int w[4];
    int n, pos;
    longint ua, ub, va, vb, pr;
    logic [63:0] r;
    w = '{8, 8, 8, 8};
    case (o.prec)
      2'b00:   begin n = 1; w[0] = 32; end
      2'b01:   begin n = 2; w[0] = 16; w[1] = 16; end
      2'b10:   n = 4;
      default: begin n = 3; w[2] = 16; end
    endcase
    r = '0;
    pos = 0;
    for (int l = 0; l < n; l++) begin
      ua = (longint'({32'd0, o.a}) >> pos) & ((longint'(1) << w[l]) - 1);
      ub = (longint'({32'd0, o.b}) >> pos) & ((longint'(1) << w[l]) - 1);
      va = (o.sa && ((ua >> (w[l] - 1)) & 1) == 1) ? ua - (longint'(1) << w[l]) : ua;
      vb = (o.sb && ((ub >> (w[l] - 1)) & 1) == 1) ? ub - (longint'(1) << w[l]) : ub;
      pr = va * vb;
      if (w[l] < 32) pr = pr & ((longint'(1) << (2 * w[l])) - 1);
      r = r | (64'(pr) << (2 * pos));
      pos += w[l];
    end
    return r;
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] v);
    for (int d = 1; d <= NR; d++)
      if (v[(m_last + d) % NR]) return (m_last + d) % NR;
    return -1;
  endfunction

  function automatic int pending_total();
    int t = 0;
    for (int i = 0; i < NR; i++) t += pend[i].size();
    return t;
  endfunction

  task automatic mdl_reset();
    m_phase = 0;
    m_rem   = 0;
    m_last  = NR - 1;
    m_count = '0;
    for (int i = 0; i < NR; i++) pend[i].delete();
    acc_id.delete();
    acc_data.delete();
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    rst_n = 1'b1;
    mdl_reset();
  endtask

  // Drives queued operations and checks the DUT each cycle against the model.
  // hold_mode >= 0: rsp_ready held low for that many RESP cycles; < 0: random traffic.
  task automatic run_engine(input int max_cyc, input int hold_mode);
    int cyc = 0;
    int hold = 0;
    int held = 0;
    int g;
    logic [NR-1:0] vmask, exp_rdy;
    while ((pending_total() > 0 || m_phase != 0) && cyc < max_cyc) begin
      for (int i = 0; i < NR; i++) begin
        op_t o;
        vmask[i] = (pend[i].size() > 0) && (hold_mode >= 0 || $urandom_range(0, 3) != 0);
        o = (pend[i].size() > 0) ? pend[i][0] : rand_op();
        if (!vmask[i]) o = rand_op();
        req_a[32*i +: 32] = o.a;
        req_b[32*i +: 32] = o.b;
        req_sa[i]         = o.sa;
        req_sb[i]         = o.sb;
        req_prec[2*i +: 2] = o.prec;
      end
      req_valid = vmask;
      if (m_phase == 2) rsp_ready = (held >= hold);
      else              rsp_ready = (hold_mode < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      exp_rdy = '0;
      g = (m_phase == 0) ? rr_pick(vmask) : -1;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      chk("op_count", 64'(op_count), 64'(m_count));
      if (m_phase == 2) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
      end
      case (m_phase)
        0: if (g >= 0) begin
          m_data  = golden(pend[g][0]);
          m_id    = g;
          m_last  = g;
          m_rem   = SETTLE;
          m_phase = 1;
          void'(pend[g].pop_front());
        end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = 2;
            held    = 0;
            hold    = (hold_mode < 0) ? $urandom_range(0, 3) : hold_mode;
          end
        end
        default: if (rsp_ready) begin
          m_phase = 0;
          m_count = m_count + 16'd1;
          acc_id.push_back(m_id);
          acc_data.push_back(m_data);
        end else held++;
      endcase
      tick();
      cyc++;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("engine_in_budget", 64'(cyc < max_cyc), 64'd1);
  endtask

  initial begin
    op_t pt;
    int  rv_seen;
    req_valid = '0; req_a = '0; req_b = '0; req_sa = '0; req_sb = '0; req_prec = '0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    mdl_reset();
    #12;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_op_count", 64'(op_count), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;

    // single operation 3*2
    pend[0].push_back(mk_op(32'd3, 32'd2, 1'b0, 1'b0, 2'b00));
    run_engine(50, 0);
    chk("single_data", acc_data[0], 64'd6);
    chk("single_id", 64'(acc_id[0]), 64'd0);
    chk("single_count", 64'(op_count), 64'd1);

    // contention from reset
    do_reset();
    pend[0].push_back(mk_op(32'd5, 32'd7, 1'b0, 1'b0, 2'b00));
    pend[1].push_back(mk_op(32'd4, 32'd4, 1'b0, 1'b0, 2'b00));
    run_engine(50, 0);
    chk("contend_first", {acc_data[0][61:0], 2'(acc_id[0])}, {62'd35, 2'd0});
    chk("contend_second", {acc_data[1][61:0], 2'(acc_id[1])}, {62'd16, 2'd1});

    // fairness: both continuously valid
    do_reset();
    for (int k = 0; k < 2; k++) begin
      pend[0].push_back(rand_op());
      pend[1].push_back(rand_op());
    end
    run_engine(80, 0);
    for (int k = 0; k < 4; k++) chk("fair_id", 64'(acc_id[k]), 64'(k % 2));
    chk("fair_count", 64'(op_count), 64'd4);

    // backpressure: five RESP cycles with rsp_ready low
    pend[0].push_back(mk_op(32'd3, 32'd2, 1'b0, 1'b0, 2'b00));
    run_engine(50, 5);
    chk("bp_data", acc_data[4], 64'd6);

    // pass-through of MIX precision and sign flag; bus scrambled after capture
    pt = mk_op(32'h04040203, 32'h10080402, 1'b1, 1'b0, 2'b11);
    pend[0].push_back(pt);
    run_engine(50, 0);
    chk("mix_data", acc_data[5], golden(pt));

    // randomized traffic
    for (int k = 0; k < 40; k++) pend[$urandom_range(0, NR - 1)].push_back(rand_op());
    run_engine(2000, -1);

    // reset one cycle after a handshake discards the operation
    req_a[31:0] = 32'd9; req_b[31:0] = 32'd9; req_sa = '0; req_sb = '0; req_prec = '0;
    req_valid = 2'b01;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_count", 64'(op_count), 64'd0);
    rv_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rsp_valid) rv_seen++;
    end
    chk("midrst_no_rsp", 64'(rv_seen), 64'd0);
    rst_n = 1'b1;
    tick();
    req_valid = 2'b11;
    #1;
    chk("midrst_first_grant", 64'(req_ready), 64'd1);
    req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
